clic_scan_arbiter: RTL and testbench
====================================

Name: clic_scan_arbiter

Overview:
- Multi-cycle arbiter that picks the highest-priority pending, enabled interrupt out of 2**INDEX_BITS vectors and presents it to the core with a req/ack handshake.
- Generalises the fixed 3-bit priority / 6-bit index CLIC configuration: priority width, index width and lanes compared per cycle are all parameters.
- Sits between the CLIC pending/enable/priority register file and the core's interrupt entry logic.

Parameters:
- PRIO_BITS, 3, width of each priority field; 0 is the lowest priority.
- INDEX_BITS, 6, vector index width; N = 2**INDEX_BITS entries.
- LANES, 8, entries compared per scan beat; must be a power of two with 1 <= LANES <= N. Beats per scan: B = N/LANES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pend_i  in  N  per-vector pending bits.
- en_i  in  N  per-vector enable bits.
- prio_i  in  N*PRIO_BITS  priority of vector k is in bits [k*PRIO_BITS +: PRIO_BITS].
- threshold_i  in  PRIO_BITS  core level; a vector is eligible only if its prio > threshold_i.
- req_o  out  1  request to core.
- req_index_o  out  INDEX_BITS  index of the requested vector.
- req_prio_o  out  PRIO_BITS  priority of the requested vector.
- ack_i  in  1  core accepts the request in this cycle.
- claim_o  out  1  one-cycle pulse: the request was taken; the register file clears pending.
- claim_index_o  out  INDEX_BITS  index to clear; valid while claim_o = 1.

Behaviour:
- Reset: req_o=0, req_index_o=0, req_prio_o=0, claim_o=0, claim_index_o=0, beat counter=0, running best invalid, state SCAN.
- Candidate: vector k is a candidate when pend_i[k] & en_i[k] & (prio_i[k] > threshold_i), unsigned compare.
- SCAN state:
  - Beat counter c runs 0..B-1 and wraps.
  - On each beat, lanes c*LANES .. c*LANES+LANES-1 are reduced combinationally and merged into the registered running best.
  - Higher prio wins. On equal prio, the lower index wins, so the earlier-held best stays.
  - On beat B-1, with the merged result valid: go to HOLD, req_o=1, load req_index_o and req_prio_o.
  - On beat B-1, with the merged result invalid: clear best, c=0, stay in SCAN.
  - Inputs are sampled live per beat. Changes to already-scanned lanes are seen on the next scan.
  - Latency from a sole candidate appearing (held stable) to req_o=1: at most 2*B cycles, at least 1.
- HOLD state:
  - req_o stays 1. req_index_o and req_prio_o stay stable (except under the optional feature).
  - Each cycle, the held entry is re-checked: pend_i, en_i and prio_i at req_index_o, against threshold_i.
  - ack_i=1: next cycle claim_o=1 and claim_index_o=req_index_o; req_o=0; go to SCAN with c=0 and best cleared. claim_o lasts exactly one cycle.
  - ack_i=0 and the held entry is no longer a candidate: withdraw. req_o=0 next cycle, no claim, go to SCAN with c=0.
  - ack_i=1 and withdrawal in the same cycle: ack wins and the claim is issued.
- B=1 (LANES=N): a full scan every cycle; HOLD is reachable one cycle after a candidate appears.
- Reset asserted mid-scan or in HOLD: immediately returns to reset values. A pending claim pulse is dropped.

Optional Feature:
- Macro: CLIC_SCAN_PREEMPT_EN.
- Defined:
  - In HOLD, a background scan keeps running.
  - At the end of each background scan, if its best prio > req_prio_o, req_index_o and req_prio_o are replaced on the next edge and req_o stays 1.
  - The core acks whatever values are present in the ack cycle; claim_index_o reflects those values.
- Undefined: no scanning in HOLD; the held request never changes until ack or withdrawal.

Test Plan (defaults N=64, LANES=8, B=8):
- Reset then idle: rst_n=0 with all inputs 0 -> all outputs 0; after release, req_o stays 0 for 40 cycles.
- Single candidate: pend/en[37]=1, prio=5, threshold=2 -> req_o=1 within 16 cycles with index 37, prio 5; ack -> claim_o pulses one cycle with claim_index_o=37.
- Tie-break: vectors 12 and 50 both prio 6 -> req_index_o=12. Then set vector 50 to prio 7 and claim 12 -> next request is index 50.
- Threshold gating and withdrawal: vector 9 at prio 3, threshold 3 -> no request. Drop threshold to 2 -> request for 9. Raise threshold to 4 while ack_i=0 -> req_o falls next cycle, no claim_o.
- Ack vs withdrawal race: in HOLD, drive ack_i=1 in the same cycle pend_i[req_index_o] falls -> claim_o=1 for that index.
- Preempt (CLIC_SCAN_PREEMPT_EN): holding vector 4 at prio 2 with ack_i=0, raise vector 60 to prio 7 -> within 8 cycles req_index_o=60 with req_o held high. Without the macro -> req_index_o remains 4.

Source files
------------

// File: rtl/clic_scan_arbiter.sv
// Multi-cycle CLIC arbiter: scans LANES vectors per beat for the highest-priority eligible
// interrupt and offers it to the core via req/ack. Optional macro CLIC_SCAN_PREEMPT_EN.
module clic_scan_arbiter #(
  parameter int PRIO_BITS  = 3,
  parameter int INDEX_BITS = 6,
  parameter int LANES      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [(1 << INDEX_BITS)-1:0]           pend_i,
  input  logic [(1 << INDEX_BITS)-1:0]           en_i,
  input  logic [(1 << INDEX_BITS)*PRIO_BITS-1:0] prio_i,
  input  logic [PRIO_BITS-1:0]                   threshold_i,
  output logic                                   req_o,
  output logic [INDEX_BITS-1:0]                  req_index_o,
  output logic [PRIO_BITS-1:0]                   req_prio_o,
  input  logic                                   ack_i,
  output logic                                   claim_o,
  output logic [INDEX_BITS-1:0]                  claim_index_o
);

  localparam int N         = 1 << INDEX_BITS;
  localparam int B         = N / LANES;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int BEAT_BITS = (B > 1) ? $clog2(B) : 1;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(B - 1);

  typedef enum logic {SCAN, HOLD} state_e;

  state_e                state_q, state_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic                  best_valid_q, best_valid_d;
  logic [INDEX_BITS-1:0] best_index_q, best_index_d;
  logic [PRIO_BITS-1:0]  best_prio_q, best_prio_d;
  logic                  req_d, claim_d;
  logic [INDEX_BITS-1:0] req_index_d, claim_index_d;
  logic [PRIO_BITS-1:0]  req_prio_d;

  logic [N-1:0]          cand;
  logic [PRIO_BITS-1:0]  prio_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_cand
    assign prio_arr[k] = prio_i[k*PRIO_BITS +: PRIO_BITS];
    assign cand[k]     = pend_i[k] & en_i[k] & (prio_arr[k] > threshold_i);
  end

  logic [INDEX_BITS-1:0] beat_base, idx;
  logic                  lane_valid, merge_valid;
  logic [INDEX_BITS-1:0] lane_index, merge_index;
  logic [PRIO_BITS-1:0]  lane_prio, merge_prio;

  assign beat_base = INDEX_BITS'(beat_q) << LANE_BITS;

  // Ascending lane order with a strict '>' keeps the lowest index on equal priority.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lane_valid = 1'b0;
    lane_index = '0;
    lane_prio  = '0;
    idx        = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = beat_base | INDEX_BITS'(l);
      if (cand[idx] && (!lane_valid || prio_arr[idx] > lane_prio)) begin
        lane_valid = 1'b1;
        lane_index = idx;
        lane_prio  = prio_arr[idx];
      end
    end
  end

  // The running best always holds lower indices than this beat, so it survives ties.
  always_comb begin
    merge_valid = best_valid_q | lane_valid;
    merge_index = best_index_q;
    merge_prio  = best_prio_q;
    if (lane_valid && (!best_valid_q || lane_prio > best_prio_q)) begin
      merge_index = lane_index;
      merge_prio  = lane_prio;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    best_valid_d  = best_valid_q;
    best_index_d  = best_index_q;
    best_prio_d   = best_prio_q;
    req_d         = req_o;
    req_index_d   = req_index_o;
    req_prio_d    = req_prio_o;
    claim_d       = 1'b0;
    claim_index_d = claim_index_o;
    unique case (state_q)
      SCAN: begin
        if (beat_q == LAST_BEAT) begin
          beat_d       = '0;
          best_valid_d = 1'b0;
          best_index_d = '0;
          best_prio_d  = '0;
          if (merge_valid) begin
            state_d     = HOLD;
            req_d       = 1'b1;
            req_index_d = merge_index;
            req_prio_d  = merge_prio;
          end
        end else begin
          beat_d       = beat_q + 1'b1;
          best_valid_d = merge_valid;
          best_index_d = merge_index;
          best_prio_d  = merge_prio;
        end
      end
      HOLD: begin
        // Ack takes precedence over a simultaneous withdrawal.
        if (ack_i || !cand[req_index_o]) begin
          claim_d       = ack_i;
          claim_index_d = ack_i ? req_index_o : claim_index_o;
          req_d         = 1'b0;
          state_d       = SCAN;
          beat_d        = '0;
          best_valid_d  = 1'b0;
          best_index_d  = '0;
          best_prio_d   = '0;
        end
`ifdef CLIC_SCAN_PREEMPT_EN
        else if (beat_q == LAST_BEAT) begin
          beat_d       = '0;
          best_valid_d = 1'b0;
          best_index_d = '0;
          best_prio_d  = '0;
          if (merge_valid && merge_prio > req_prio_o) begin
            req_index_d = merge_index;
            req_prio_d  = merge_prio;
          end
        end else begin
          beat_d       = beat_q + 1'b1;
          best_valid_d = merge_valid;
          best_index_d = merge_index;
          best_prio_d  = merge_prio;
        end
`else
        else begin
          state_d = HOLD;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SCAN;
      beat_q        <= '0;
      best_valid_q  <= 1'b0;
      best_index_q  <= '0;
      best_prio_q   <= '0;
      req_o         <= 1'b0;
      req_index_o   <= '0;
      req_prio_o    <= '0;
      claim_o       <= 1'b0;
      claim_index_o <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      best_valid_q  <= best_valid_d;
      best_index_q  <= best_index_d;
      best_prio_q   <= best_prio_d;
      req_o         <= req_d;
      req_index_o   <= req_index_d;
      req_prio_o    <= req_prio_d;
      claim_o       <= claim_d;
      claim_index_o <= claim_index_d;
    end
  end

endmodule

// File: tb/tb_clic_scan_arbiter.sv
// Scoreboard bench for clic_scan_arbiter at default parameters (N=64, LANES=8, B=8).
module tb_clic_scan_arbiter;
  localparam int PRIO_BITS  = 3;
  localparam int INDEX_BITS = 6;
  localparam int LANES      = 8;
  localparam int N          = 1 << INDEX_BITS;
  localparam int B          = N / LANES;

  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic [PRIO_BITS-1:0]  prio;
  } req_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           pend = '0;
  logic [N-1:0]           en = '0;
  logic [N*PRIO_BITS-1:0] prio = '0;
  logic [PRIO_BITS-1:0]   threshold = '0;
  logic                   ack = 1'b0;
  logic                   req;
  logic [INDEX_BITS-1:0]  req_index;
  logic [PRIO_BITS-1:0]   req_prio;
  logic                   claim;
  logic [INDEX_BITS-1:0]  claim_index;

  req_t                  exp_req_q[$];
  logic [INDEX_BITS-1:0] exp_claim_q[$];
  int total = 0;
  int bad   = 0;

  clic_scan_arbiter #(.PRIO_BITS(PRIO_BITS), .INDEX_BITS(INDEX_BITS), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .pend_i(pend), .en_i(en), .prio_i(prio),
    .threshold_i(threshold), .req_o(req), .req_index_o(req_index), .req_prio_o(req_prio),
    .ack_i(ack), .claim_o(claim), .claim_index_o(claim_index)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input bit p, input int pr);
    pend[k] = p;
    en[k]   = p;
    prio[k*PRIO_BITS +: PRIO_BITS] = PRIO_BITS'(pr);
  endtask

  task automatic clear_inputs();
    pend = '0; en = '0; prio = '0; threshold = '0; ack = 1'b0;
  endtask

  task automatic wait_req(input int max, output int cycles, output bit seen);
    cycles = 0;
    seen   = req;
    while (!seen && cycles < max) begin
      tick();
      cycles++;
      seen = req;
    end
  endtask

  task automatic test_reset();
    int highs;
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({req, req_index, req_prio, claim, claim_index} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: req=%0b idx=%0d prio=%0d claim=%0b cidx=%0d, required all 0",
               req, req_index, req_prio, claim, claim_index);
    end
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req !== 1'b0) highs++;
    end
    total++;
    if (highs != 0) begin
      bad++;
      $display("FAIL idle_no_req: req_o high %0d cycles, required 0", highs);
    end
  endtask

  task automatic test_single();
    int cyc; bit seen; req_t exp; logic [INDEX_BITS-1:0] ec;
    set_vec(37, 1, 5);
    threshold = 3'd2;
    exp_req_q.push_back('{index: 6'd37, prio: 3'd5});
    wait_req(2*B, cyc, seen);
    exp = exp_req_q.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL single_req_timeout: req_o=%0b after %0d cycles, required 1", req, cyc);
    end else if ({req_index, req_prio} !== exp) begin
      bad++;
      $display("FAIL single_req_value: idx=%0d prio=%0d, required idx=%0d prio=%0d",
               req_index, req_prio, exp.index, exp.prio);
    end
    ack = 1'b1;
    exp_claim_q.push_back(6'd37);
    tick();
    ack = 1'b0;
    set_vec(37, 0, 0);
    ec = exp_claim_q.pop_front();
    total++;
    if (claim !== 1'b1 || claim_index !== ec || req !== 1'b0) begin
      bad++;
      $display("FAIL single_claim: claim=%0b cidx=%0d req=%0b, required claim=1 cidx=%0d req=0",
               claim, claim_index, req, ec);
    end
    tick();
    total++;
    if (claim !== 1'b0) begin
      bad++;
      $display("FAIL single_claim_pulse: claim=%0b in second cycle, required 0", claim);
    end
  endtask

  task automatic test_tiebreak();
    int cyc; bit seen; req_t exp; logic [INDEX_BITS-1:0] ec;
    clear_inputs();
    set_vec(12, 1, 6);
    set_vec(50, 1, 6);
    exp_req_q.push_back('{index: 6'd12, prio: 3'd6});
    wait_req(2*B, cyc, seen);
    exp = exp_req_q.pop_front();
    total++;
    if (!seen || {req_index, req_prio} !== exp) begin
      bad++;
      $display("FAIL tie_first: req=%0b idx=%0d prio=%0d, required req=1 idx=%0d prio=%0d",
               req, req_index, req_prio, exp.index, exp.prio);
    end
    set_vec(50, 1, 7);
    ack = 1'b1;
    exp_claim_q.push_back(6'd12);
    tick();
    ack = 1'b0;
    set_vec(12, 0, 0);
    ec = exp_claim_q.pop_front();
    total++;
    if (claim !== 1'b1 || claim_index !== ec) begin
      bad++;
      $display("FAIL tie_claim: claim=%0b cidx=%0d, required claim=1 cidx=%0d", claim, claim_index, ec);
    end
    exp_req_q.push_back('{index: 6'd50, prio: 3'd7});
    wait_req(2*B, cyc, seen);
    exp = exp_req_q.pop_front();
    total++;
    if (!seen || {req_index, req_prio} !== exp) begin
      bad++;
      $display("FAIL tie_second: req=%0b idx=%0d prio=%0d, required req=1 idx=%0d prio=%0d",
               req, req_index, req_prio, exp.index, exp.prio);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    set_vec(50, 0, 0);
    tick();
  endtask

  task automatic test_threshold();
    int cyc; bit seen; req_t exp; int claims;
    clear_inputs();
    set_vec(9, 1, 3);
    threshold = 3'd3;
    wait_req(2*B + 4, cyc, seen);
    total++;
    if (seen) begin
      bad++;
      $display("FAIL thr_gated: req=%0b idx=%0d, required req=0 with prio==threshold", req, req_index);
    end
    threshold = 3'd2;
    exp_req_q.push_back('{index: 6'd9, prio: 3'd3});
    wait_req(2*B, cyc, seen);
    exp = exp_req_q.pop_front();
    total++;
    if (!seen || {req_index, req_prio} !== exp) begin
      bad++;
      $display("FAIL thr_req: req=%0b idx=%0d prio=%0d, required req=1 idx=%0d prio=%0d",
               req, req_index, req_prio, exp.index, exp.prio);
    end
    threshold = 3'd4;
    tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL thr_withdraw: req=%0b one cycle after threshold raise, required 0", req);
    end
    claims = (claim === 1'b1) ? 1 : 0;
    for (int i = 0; i < 2*B; i++) begin
      tick();
      if (claim !== 1'b0 || req !== 1'b0) claims++;
    end
    total++;
    if (claims != 0) begin
      bad++;
      $display("FAIL thr_no_claim: %0d cycles with claim or req high, required 0", claims);
    end
  endtask

  task automatic test_race();
    int cyc; bit seen; logic [INDEX_BITS-1:0] ec;
    clear_inputs();
    set_vec(20, 1, 4);
    wait_req(2*B, cyc, seen);
    total++;
    if (!seen || req_index !== 6'd20) begin
      bad++;
      $display("FAIL race_req: req=%0b idx=%0d, required req=1 idx=20", req, req_index);
    end
    ack = 1'b1;
    set_vec(20, 0, 0);
    exp_claim_q.push_back(6'd20);
    tick();
    ack = 1'b0;
    ec = exp_claim_q.pop_front();
    total++;
    if (claim !== 1'b1 || claim_index !== ec || req !== 1'b0) begin
      bad++;
      $display("FAIL race_claim: claim=%0b cidx=%0d req=%0b, required claim=1 cidx=%0d req=0",
               claim, claim_index, req, ec);
    end
    tick();
  endtask

  task automatic test_preempt();
    int cyc; bit seen; int drops; logic [INDEX_BITS-1:0] ec;
    clear_inputs();
    set_vec(4, 1, 2);
    wait_req(2*B, cyc, seen);
    total++;
    if (!seen || req_index !== 6'd4 || req_prio !== 3'd2) begin
      bad++;
      $display("FAIL preempt_hold: req=%0b idx=%0d prio=%0d, required req=1 idx=4 prio=2",
               req, req_index, req_prio);
    end
    set_vec(60, 1, 7);
    drops = 0;
`ifdef CLIC_SCAN_PREEMPT_EN
    for (int i = 0; i < B && req_index !== 6'd60; i++) begin
      tick();
      if (req !== 1'b1) drops++;
    end
    exp_claim_q.push_back(6'd60);
    total++;
    if (req_index !== 6'd60 || req_prio !== 3'd7 || drops != 0) begin
      bad++;
      $display("FAIL preempt_replace: idx=%0d prio=%0d drops=%0d, required idx=60 prio=7 drops=0",
               req_index, req_prio, drops);
    end
`else
    for (int i = 0; i < 3*B; i++) begin
      tick();
      if (req !== 1'b1) drops++;
    end
    exp_claim_q.push_back(6'd4);
    total++;
    if (req_index !== 6'd4 || req_prio !== 3'd2 || drops != 0) begin
      bad++;
      $display("FAIL preempt_stable: idx=%0d prio=%0d drops=%0d, required idx=4 prio=2 drops=0",
               req_index, req_prio, drops);
    end
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
    set_vec(4, 0, 0);
    set_vec(60, 0, 0);
    ec = exp_claim_q.pop_front();
    total++;
    if (claim !== 1'b1 || claim_index !== ec) begin
      bad++;
      $display("FAIL preempt_claim: claim=%0b cidx=%0d, required claim=1 cidx=%0d", claim, claim_index, ec);
    end
    tick();
  endtask

  task automatic test_reset_in_hold();
    int cyc; bit seen;
    clear_inputs();
    set_vec(30, 1, 1);
    wait_req(2*B, cyc, seen);
    total++;
    if (!seen || req_index !== 6'd30) begin
      bad++;
      $display("FAIL rst_hold_req: req=%0b idx=%0d, required req=1 idx=30", req, req_index);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req, req_index, req_prio, claim} !== '0) begin
      bad++;
      $display("FAIL rst_hold_async: req=%0b idx=%0d prio=%0d claim=%0b, required all 0",
               req, req_index, req_prio, claim);
    end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tiebreak();
    test_threshold();
    test_race();
    test_preempt();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
